// File: rtl/max_argmax_stream.sv
// Running max/argmax over a multi-beat vector: one combinational per-beat
// max_argmax is reused every beat, and the whole-vector result goes out on a valid/ready port.

module max_argmax #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 3
) (
    input  logic [(2**SIZE)*WIDTH-1:0] data,
    output logic [WIDTH-1:0]           max_val,
    output logic [SIZE-1:0]            max_idx
);
    localparam int N = 2**SIZE;

    logic [WIDTH-1:0] elem [N];

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_unpack
        assign elem[gi] = data[WIDTH*(gi+1)-1 -: WIDTH];
    end

    // Strict compare keeps the lowest index among equal maxima.
    always_comb begin
        max_val = elem[0];
        max_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (elem[i] > max_val) begin
                max_val = elem[i];
                max_idx = SIZE'(i);
            end
        end
    end
endmodule

module max_argmax_stream #(
    parameter int WIDTH      = 8,
    parameter int SIZE       = 3,
    parameter int MAX_CHUNKS = 16,
    parameter int IDX_W      = SIZE + $clog2(MAX_CHUNKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(2**SIZE)*WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_max,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_err
);
    localparam int CHUNK_W = $clog2(MAX_CHUNKS);
    localparam int CNT_W   = CHUNK_W + 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_CHUNKS);

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             first_reg, first_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] chunk_max;
    logic [SIZE-1:0]  chunk_arg;

    max_argmax #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_max_argmax (
        .data    (in_data),
        .max_val (chunk_max),
        .max_idx (chunk_arg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_ACC;
            beat_cnt_reg <= '0;
            max_reg      <= '0;
            idx_reg      <= '0;
            first_reg    <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            max_reg      <= max_next;
            idx_reg      <= idx_next;
            first_reg    <= first_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        max_next      = max_reg;
        idx_next      = idx_reg;
        first_next    = first_reg;
        err_next      = err_reg;
        case (state_reg)
            S_ACC: begin
                if (in_valid) begin
                    // Beats past the window are swallowed so the producer never stalls.
                    if (beat_cnt_reg == CNT_SAT) begin
                        err_next = 1'b1;
                    end else begin
                        if (first_reg || (chunk_max > max_reg)) begin
                            max_next = chunk_max;
                            idx_next = {beat_cnt_reg[CHUNK_W-1:0], chunk_arg};
                        end
                        first_next    = 1'b0;
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                    if (in_last) begin
                        state_next = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next    = S_ACC;
                    beat_cnt_next = '0;
                    first_next    = 1'b1;
                    err_next      = 1'b0;
                end
            end
            default: state_next = S_ACC;
        endcase
    end

    // in_ready looks only at state and rst, never at out_ready.
    assign in_ready  = (state_reg == S_ACC) && !rst;
    assign out_valid = (state_reg == S_OUT);
    assign out_max   = max_reg;
    assign out_idx   = idx_reg;
    assign out_err   = err_reg;
endmodule

// File: tb/tb_max_argmax_stream.sv
// Directed and random vectors for max_argmax_stream with a queue scoreboard
// of expected {max, idx, err} results.

module tb_max_argmax_stream;
    localparam int WIDTH      = 8;
    localparam int SIZE       = 3;
    localparam int MAX_CHUNKS = 4;
    localparam int IDX_W      = 5;

    typedef struct {
        logic [7:0]       max;
        logic [IDX_W-1:0] idx;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_max;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;

    int passed = 0;
    int total  = 0;

    exp_t        sb_q[$];
    logic [63:0] beat_q[$];
    logic [7:0]  vec_q[$];

    max_argmax_stream #(
        .WIDTH      (WIDTH),
        .SIZE       (SIZE),
        .MAX_CHUNKS (MAX_CHUNKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [63:0] beat(input int e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7[7:0], e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    task automatic add_beat(input logic [63:0] d);
        beat_q.push_back(d);
        for (int i = 0; i < 8; i++) vec_q.push_back(d[8*i +: 8]);
    endtask

    task automatic sb_push(input int m, input int idx, input bit err);
        exp_t e;
        e.max = m[7:0];
        e.idx = idx[IDX_W-1:0];
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Flat scan over global element order of the first MAX_CHUNKS beats.
    task automatic sb_push_model();
        int lim = beat_q.size() > MAX_CHUNKS ? MAX_CHUNKS * 8 : beat_q.size() * 8;
        int m = 0;
        int idx = 0;
        for (int i = 0; i < lim; i++) begin
            if (i == 0 || int'(vec_q[i]) > m) begin
                m   = int'(vec_q[i]);
                idx = i;
            end
        end
        sb_push(m, idx, beat_q.size() > MAX_CHUNKS);
    endtask

    // Entered and left at a negedge; returns after the accepting posedge.
    task automatic send_beat(input logic [63:0] d, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic collect(input int hold);
        int guard = 0;
        exp_t e;
        logic [7:0]       m0;
        logic [IDX_W-1:0] i0;
        logic             e0;
        check("latency_valid", out_valid, 1);
        while (out_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        m0 = out_max;
        i0 = out_idx;
        e0 = out_err;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_max", out_max, m0);
            check("hold_idx", out_idx, i0);
            check("hold_err", out_err, e0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (sb_q.size() == 0) begin
            total++;
            $error("FAIL sb_underflow: observed result with no expected entry, expected queue nonempty");
        end else begin
            e = sb_q.pop_front();
            check("out_max", out_max, e.max);
            check("out_idx", out_idx, e.idx);
            check("out_err", out_err, e.err);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    task automatic run_vec(input int hold);
        int n = beat_q.size();
        for (int i = 0; i < n; i++) send_beat(beat_q[i], i == n - 1);
        beat_q.delete();
        vec_q.delete();
        collect(hold);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max", out_max, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_err", out_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Single beat, ascending
        add_beat(beat(10, 20, 30, 40, 50, 60, 70, 80));
        sb_push(80, 7, 0);
        run_vec(0);

        // Three beats, winner in the middle beat
        add_beat(beat(1, 2, 50, 3, 4, 5, 6, 7));
        add_beat(beat(10, 20, 30, 40, 50, 90, 60, 70));
        add_beat(beat(70, 1, 2, 3, 4, 5, 6, 7));
        sb_push(90, 13, 0);
        run_vec(0);

        // Ties within and across beats
        add_beat(beat(50, 30, 80, 20, 80, 10, 80, 40));
        add_beat(beat(80, 0, 0, 0, 0, 0, 0, 0));
        sb_push(80, 2, 0);
        run_vec(0);
        add_beat(beat(42, 42, 42, 42, 42, 42, 42, 42));
        sb_push(42, 0, 0);
        run_vec(0);

        // All-zero vector
        add_beat(64'd0);
        add_beat(64'd0);
        sb_push(0, 0, 0);
        run_vec(0);

        // Backpressure for 5 cycles
        add_beat(beat(3, 9, 200, 4, 5, 6, 7, 8));
        sb_push(200, 2, 0);
        run_vec(5);

        // Overflow: fifth beat ignored apart from err
        add_beat(beat(5, 5, 5, 5, 5, 5, 5, 5));
        add_beat(beat(1, 99, 2, 3, 4, 5, 6, 7));
        add_beat(beat(98, 97, 96, 95, 94, 93, 92, 91));
        add_beat(beat(10, 11, 12, 13, 14, 15, 16, 17));
        add_beat(beat(0, 0, 255, 0, 0, 0, 0, 0));
        sb_push(99, 9, 1);
        run_vec(0);

        // Exactly MAX_CHUNKS beats is legal; err cleared from the previous vector
        add_beat(beat(1, 1, 1, 1, 1, 1, 1, 1));
        add_beat(beat(2, 2, 2, 2, 2, 2, 2, 2));
        add_beat(beat(3, 3, 3, 3, 3, 3, 3, 3));
        add_beat(beat(4, 4, 4, 4, 4, 4, 4, 200));
        sb_push(200, 31, 0);
        run_vec(0);

        // Reset mid-vector discards the partial result
        send_beat(beat(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
        send_beat(beat(9, 200, 9, 9, 9, 9, 9, 9), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        add_beat(beat(1, 2, 3, 15, 4, 5, 6, 7));
        sb_push(15, 3, 0);
        run_vec(0);

        // Random vectors with small values to provoke ties, checked by the flat model
        for (int v = 0; v < 4; v++) begin
            int nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                logic [63:0] d;
                for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'($urandom_range(0, 20));
                add_beat(d);
            end
            sb_push_model();
            run_vec(v % 2);
        end

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
